rr_arbiter_8: RTL and testbench

Eight-requester round-robin arbiter that shares one downstream resource, such as the 8-to-3 encoded select path, between eight clients. It encodes the winning request into a 3-bit grant index and holds the grant until the owner releases it. It also enforces an optional hold limit and rotates priority so that no requester starves. It sits between the client request lines and the shared select/datapath, and drives the resource's 3-bit select from `grant_id`.

---
 rtl/arb_pkg.sv | 29 ++
 rtl/rr_priority_encoder.sv | 35 +++
 rtl/rr_arbiter_8.sv | 146 ++++++++++++++
 tb/tb_rr_arbiter_8.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared sizes, state encoding and helpers for the eight-way
//               round-robin arbiter and its rotated priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int N_REQ  = 8;   // number of requesting clients
    localparam int ID_W   = 3;   // width of a client index
    localparam int HOLD_W = 8;   // width of the hold counter (saturates at 255)

    // Arbiter control state, explicitly one bit wide
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Expand a client index into its one-hot grant vector
    function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_encoder
// Description : Combinational rotated 8-to-3 priority encoder. Returns the
//               first set request bit scanning ptr, ptr+1, ... wrapping mod 8.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_encoder
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  id,
    output logic             valid
);

    logic [ID_W-1:0] w_idx;

    // Scan from the farthest offset down to offset 0 so the last hit wins,
    // which leaves the requester closest to ptr as the result without a break.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        w_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = ptr + ID_W'(i);
            if (req[w_idx]) begin
                id    = w_idx;
                valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_8
// Description : Eight-requester round-robin arbiter with registered one-hot
//               and binary grant, owner release, optional hold limit and
//               priority rotation on every release.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_valid,
    output logic             timeout
);

    localparam logic [HOLD_W-1:0] c_max_hold = HOLD_W'(MAX_HOLD);
    localparam logic              c_limit_en = (MAX_HOLD != 0);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [ID_W-1:0]   r_ptr;
    logic [HOLD_W-1:0] r_cnt;
    logic [N_REQ-1:0]  r_grant;
    logic [ID_W-1:0]   r_grant_id;
    logic              r_grant_valid;
    logic              r_timeout;

    logic [ID_W-1:0]   w_ptr_eff;
    logic [ID_W-1:0]   w_pick_id;
    logic              w_pick_valid;
    logic              w_owner_drop;
    logic              w_hold_hit;
    logic              w_release;

    logic [ID_W-1:0]   w_ptr_nxt;
    logic [HOLD_W-1:0] w_cnt_nxt;
    logic [N_REQ-1:0]  w_grant_nxt;
    logic [ID_W-1:0]   w_grant_id_nxt;
    logic              w_grant_valid_nxt;
    logic              w_timeout_nxt;

    // Release conditions for the current owner; the pointer moves past the
    // owner before the next pick so it can re-win only when nobody else asks.
    always_comb begin
        w_owner_drop = ~req[r_grant_id];
        w_hold_hit   = c_limit_en && (r_cnt == c_max_hold);
        w_release    = (r_state == GRANT) && (done || w_owner_drop || w_hold_hit);
        w_ptr_eff    = w_release ? (r_grant_id + ID_W'(1)) : r_ptr;
    end

    rr_priority_encoder u_pick (
        .req   (req),
        .ptr   (w_ptr_eff),
        .id    (w_pick_id),
        .valid (w_pick_valid)
    );

    // State and datapath registers; reset clears everything at the edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

    // Next-state: stay granted across a release whenever someone is waiting
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pick_valid) w_state_nxt = GRANT;
            GRANT:   if (w_release && !w_pick_valid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the grant outputs, pointer and hold counter
    always_comb begin
        w_ptr_nxt         = r_ptr;
        w_cnt_nxt         = r_cnt;
        w_grant_nxt       = r_grant;
        w_grant_id_nxt    = r_grant_id;
        w_grant_valid_nxt = r_grant_valid;
        w_timeout_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt       = id_to_onehot(w_pick_id);
                    w_grant_id_nxt    = w_pick_id;
                    w_grant_valid_nxt = 1'b1;
                    w_cnt_nxt         = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_ptr_nxt = w_ptr_eff;
                    // Only a pure hold-limit release is reported as a timeout
                    w_timeout_nxt = w_hold_hit && !done && !w_owner_drop;
                    if (w_pick_valid) begin
                        w_grant_nxt    = id_to_onehot(w_pick_id);
                        w_grant_id_nxt = w_pick_id;
                        w_cnt_nxt      = HOLD_W'(1);
                    end else begin
                        // grant_id keeps its last value while idle
                        w_grant_nxt       = '0;
                        w_grant_valid_nxt = 1'b0;
                        w_cnt_nxt         = '0;
                    end
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_grant_nxt       = '0;
                w_grant_valid_nxt = 1'b0;
            end
        endcase
    end

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_8
// Description : Self-checking bench for rr_arbiter_8: a reference model
//               queues the expected outputs per edge, plus directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] id;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic       m_valid = 1'b0;
    logic [2:0] m_id    = '0;
    logic [2:0] m_ptr   = '0;
    int         m_cnt   = 0;
    logic       m_to    = 1'b0;

    function automatic bit model_pick(input logic [7:0] r, input logic [2:0] p,
                                      output logic [2:0] w);
        for (int k = 0; k < 8; k++) begin
            int j;
            j = (int'(p) + k) % 8;
            if (r[j]) begin
                w = 3'(j);
                return 1'b1;
            end
        end
        w = '0;
        return 1'b0;
    endfunction

    // Advance the model by one edge using the inputs now applied; queue result
    task automatic model_advance();
        exp_t       e;
        logic [2:0] w;
        bit         f;
        logic       drop, lim;
        m_to = 1'b0;
        if (rst) begin
            m_valid = 1'b0; m_id = '0; m_ptr = '0; m_cnt = 0;
        end else if (!m_valid) begin
            f = model_pick(req, m_ptr, w);
            if (f) begin m_valid = 1'b1; m_id = w; m_cnt = 1; end
        end else begin
            drop = !req[m_id];
            lim  = (MAX_HOLD != 0) && (m_cnt == MAX_HOLD);
            if (done || drop || lim) begin
                m_to  = lim && !done && !drop;
                m_ptr = (m_id == 3'd7) ? 3'd0 : m_id + 3'd1;
                f = model_pick(req, m_ptr, w);
                if (f) begin m_id = w; m_cnt = 1; end
                else begin m_valid = 1'b0; m_cnt = 0; end
            end else if (m_cnt < 255) begin
                m_cnt++;
            end
        end
        e.grant = m_valid ? (8'h01 << m_id) : 8'h00;
        e.id    = m_id;
        e.valid = m_valid;
        e.to    = m_to;
        sb_q.push_back(e);
    endtask

    // One clock: queue expectation, take the edge, compare against the queue
    task automatic step();
        exp_t e;
        model_advance();
        @(posedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: got no expected entry, required one at t=%0t", $time);
        end else begin
            e = sb_q.pop_front();
            if (grant !== e.grant) begin
                n_fail++;
                $display("FAIL sb_grant: got %h required %h at t=%0t", grant, e.grant, $time);
            end
            n_checks++;
            if (grant_id !== e.id) begin
                n_fail++;
                $display("FAIL sb_grant_id: got %0d required %0d at t=%0t", grant_id, e.id, $time);
            end
            n_checks++;
            if (grant_valid !== e.valid) begin
                n_fail++;
                $display("FAIL sb_valid: got %b required %b at t=%0t", grant_valid, e.valid, $time);
            end
            n_checks++;
            if (timeout !== e.to) begin
                n_fail++;
                $display("FAIL sb_timeout: got %b required %b at t=%0t", timeout, e.to, $time);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 8'h00; done = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 8'h01; done = 1'b0;
        step();
        step();
        n_checks++;
        if (grant !== 8'h00 || grant_id !== 3'd0 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%0d/%b/%b required 00/0/0/0",
                     grant, grant_id, grant_valid, timeout);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (grant !== 8'h01 || grant_id !== 3'd0 || grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant: got %h/%0d/%b required 01/0/1", grant, grant_id, grant_valid);
        end
    endtask

    task automatic test_round_robin();
        bit gap;
        gap = 1'b0;
        do_reset();
        req = 8'hFF; done = 1'b0;
        step();
        for (int r = 0; r < 8; r++) begin
            done = 1'b0; step(); if (!grant_valid) gap = 1'b1;
            step();              if (!grant_valid) gap = 1'b1;
            done = 1'b1; step(); if (!grant_valid) gap = 1'b1;
            n_checks++;
            if (grant_id !== 3'((r + 1) % 8)) begin
                n_fail++;
                $display("FAIL rr_sequence: got %0d required %0d", grant_id, (r + 1) % 8);
            end
        end
        done = 1'b0;
        n_checks++;
        if (gap) begin
            n_fail++;
            $display("FAIL rr_no_gap: got grant_valid gap, required none");
        end
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        do_reset();
        req = 8'b0010_0100; done = 1'b0;
        step();
        for (int k = 0; k < 15; k++) begin
            step();
            pulses += int'(timeout);
        end
        n_checks++;
        if (grant_id !== 3'd2) begin
            n_fail++;
            $display("FAIL hold_before_limit: got %0d required 2", grant_id);
        end
        step();
        pulses += int'(timeout);
        n_checks++;
        if (grant_id !== 3'd5 || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL limit_release: got id %0d to %b required id 5 to 1", grant_id, timeout);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            pulses += int'(timeout);
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL timeout_pulses: got %0d required 1", pulses);
        end
    endtask

    task automatic test_regrant();
        do_reset();
        req = 8'h08; done = 1'b0;
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        n_checks++;
        if (grant !== 8'h08 || grant_id !== 3'd3 || grant_valid !== 1'b1 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL self_regrant: got %h/%0d/%b/%b required 08/3/1/0",
                     grant, grant_id, grant_valid, timeout);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 8'h80; done = 1'b0;
        step();
        req = 8'h02;
        step();
        n_checks++;
        if (grant_id !== 3'd1 || grant_valid !== 1'b1 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL ptr_wrap: got %0d/%b/%b required 1/1/0", grant_id, grant_valid, timeout);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 8'h20; done = 1'b0;
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (grant !== 8'h00 || grant_id !== 3'd0 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h/%0d/%b/%b required 00/0/0/0",
                     grant, grant_id, grant_valid, timeout);
        end
        rst = 1'b0; req = 8'b0010_0001;
        step();
        n_checks++;
        if (grant_id !== 3'd0 || grant !== 8'h01) begin
            n_fail++;
            $display("FAIL post_reset_ptr: got %0d/%h required 0/01", grant_id, grant);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 8'h01; done = 1'b0;
        step();
        done = 1'b1; req = 8'h03;
        step();
        n_checks++;
        if (grant_id !== 3'd1 || grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL done_new_req: got %0d/%b required 1/1", grant_id, grant_valid);
        end
        done = 1'b0; req = 8'h00;
        step();
        n_checks++;
        if (grant_valid !== 1'b0 || grant !== 8'h00 || grant_id !== 3'd1) begin
            n_fail++;
            $display("FAIL idle_hold_id: got %h/%0d/%b required 00/1/0", grant, grant_id, grant_valid);
        end
        req = 8'h01;
        step();
        n_checks++;
        if (grant_id !== 3'd0 || grant !== 8'h01) begin
            n_fail++;
            $display("FAIL idle_regrant: got %0d/%h required 0/01", grant_id, grant);
        end
    endtask

    task automatic test_random();
        do_reset();
        req = 8'h00; done = 1'b0;
        for (int c = 0; c < 500; c++) begin
            rst  = ($urandom_range(0, 99) == 0);
            req  = req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            done = ($urandom_range(0, 19) == 0);
            step();
        end
        rst = 1'b0; done = 1'b0; req = 8'h00;
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; done = 1'b0;
        test_reset();
        test_round_robin();
        test_timeout();
        test_regrant();
        test_wrap();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
